// File: rtl/core_tb_memory.sv
// core_tb_memory: behavioural instruction/data RAM model for riscv_core benches.
// Two independent req/gnt/valid ports, one-cycle read latency.
//
// Parameters:
//   IRAM_WORDS  instruction RAM depth (32-bit words)
//   DRAM_WORDS  data RAM depth (32-bit words)
// Ports:
//   clk, reset                    clock, async active-high reset
//   instr_req/addr                fetch request and byte address
//   instr_gnt/rdata/err/valid     fetch grant and response
//   data_req/wr/addr/wdata/byteen load/store request
//   data_gnt/rdata/valid          data grant and response
// Optional feature: define TB_MEM_STALL_EN to insert pseudo-random grant
// stalls driven by one 8-bit LFSR per port.

module core_tb_memory_ram #(
  parameter int WORDS = 16384,
  parameter int AW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] idx_i,
  input  logic [31:0]   wdata_i,
  input  logic [3:0]    byteen_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] MEM [0:WORDS-1];

  assign rdata_o = MEM[idx_i];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (byteen_i[b]) begin
          MEM[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

endmodule

module core_tb_memory #(
  parameter int IRAM_WORDS = 16384,
  parameter int DRAM_WORDS = 16384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic        instr_gnt,
  output logic [31:0] instr_rdata,
  output logic        instr_err,
  output logic        instr_valid,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_byteen,
  output logic        data_gnt,
  output logic [31:0] data_rdata,
  output logic        data_valid
);

  localparam int IAW = (IRAM_WORDS > 1) ? $clog2(IRAM_WORDS) : 1;
  localparam int DAW = (DRAM_WORDS > 1) ? $clog2(DRAM_WORDS) : 1;

  logic [29:0] i_idx;
  logic [29:0] d_idx;
  logic        i_ok;
  logic        d_ok;
  logic        i_acc;
  logic        d_acc;
  logic        d_we;
  logic [31:0] i_word;
  logic [31:0] d_word;
  logic        unused_addr_lsb;

  logic        instr_valid_q, instr_valid_d;
  logic        instr_err_q, instr_err_d;
  logic [31:0] instr_rdata_q, instr_rdata_d;
  logic        data_valid_q, data_valid_d;
  logic [31:0] data_rdata_q, data_rdata_d;

  assign i_idx = instr_addr[31:2];
  assign d_idx = data_addr[31:2];
  assign unused_addr_lsb = ^data_addr[1:0];

  assign i_ok = (instr_addr[1:0] == 2'b00) &&
                ({2'b00, i_idx} < 32'(IRAM_WORDS));
  assign d_ok = {2'b00, d_idx} < 32'(DRAM_WORDS);

`ifdef TB_MEM_STALL_EN
  logic [7:0] ilfsr_q, ilfsr_d;
  logic [7:0] dlfsr_q, dlfsr_d;

  // Fibonacci LFSR, taps 8,6,5,4
  assign ilfsr_d = {ilfsr_q[6:0],
                    ilfsr_q[7] ^ ilfsr_q[5] ^ ilfsr_q[4] ^ ilfsr_q[3]};
  assign dlfsr_d = {dlfsr_q[6:0],
                    dlfsr_q[7] ^ dlfsr_q[5] ^ dlfsr_q[4] ^ dlfsr_q[3]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ilfsr_q <= 8'hA5;
      dlfsr_q <= 8'hA5;
    end else begin
      ilfsr_q <= ilfsr_d;
      dlfsr_q <= dlfsr_d;
    end
  end

  assign instr_gnt = instr_req & ~reset & (ilfsr_q[1:0] != 2'b00);
  assign data_gnt  = data_req  & ~reset & (dlfsr_q[1:0] != 2'b00);
`else
  assign instr_gnt = instr_req & ~reset;
  assign data_gnt  = data_req  & ~reset;
`endif

  assign i_acc = instr_req & instr_gnt;
  assign d_acc = data_req & data_gnt;
  assign d_we  = d_acc & data_wr & d_ok;

  core_tb_memory_ram #(.WORDS(IRAM_WORDS), .AW(IAW)) iram (
    .clk      (clk),
    .we_i     (1'b0),
    .idx_i    (i_idx[IAW-1:0]),
    .wdata_i  (32'h0),
    .byteen_i (4'h0),
    .rdata_o  (i_word)
  );

  core_tb_memory_ram #(.WORDS(DRAM_WORDS), .AW(DAW)) dram (
    .clk      (clk),
    .we_i     (d_we),
    .idx_i    (d_idx[DAW-1:0]),
    .wdata_i  (data_wdata),
    .byteen_i (data_byteen),
    .rdata_o  (d_word)
  );

  always_comb begin
    instr_valid_d = i_acc;
    instr_err_d   = i_acc & ~i_ok;
    instr_rdata_d = instr_rdata_q;
    if (i_acc) begin
      instr_rdata_d = i_ok ? i_word : 32'h0;
    end
  end

  // stores leave the read register untouched
  always_comb begin
    data_valid_d = d_acc;
    data_rdata_d = data_rdata_q;
    if (d_acc && !data_wr) begin
      data_rdata_d = d_ok ? d_word : 32'h0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_valid_q <= 1'b0;
      instr_err_q   <= 1'b0;
      instr_rdata_q <= 32'h0;
      data_valid_q  <= 1'b0;
      data_rdata_q  <= 32'h0;
    end else begin
      instr_valid_q <= instr_valid_d;
      instr_err_q   <= instr_err_d;
      instr_rdata_q <= instr_rdata_d;
      data_valid_q  <= data_valid_d;
      data_rdata_q  <= data_rdata_d;
    end
  end

  assign instr_valid = instr_valid_q;
  assign instr_err   = instr_err_q;
  assign instr_rdata = instr_rdata_q;
  assign data_valid  = data_valid_q;
  assign data_rdata  = data_rdata_q;

endmodule

// File: tb/tb_core_tb_memory.sv
// tb_core_tb_memory: scoreboard bench for core_tb_memory.
// Expected responses are queued at grant and compared at valid.

module tb_core_tb_memory;

  localparam int IW = 64;
  localparam int DW = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_req = 1'b0;
  logic [31:0] instr_addr = 32'h0;
  logic        instr_gnt;
  logic [31:0] instr_rdata;
  logic        instr_err;
  logic        instr_valid;
  logic        data_req = 1'b0;
  logic        data_wr = 1'b0;
  logic [31:0] data_addr = 32'h0;
  logic [31:0] data_wdata = 32'h0;
  logic [3:0]  data_byteen = 4'h0;
  logic        data_gnt;
  logic [31:0] data_rdata;
  logic        data_valid;

  core_tb_memory #(.IRAM_WORDS(IW), .DRAM_WORDS(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_req   (instr_req),
    .instr_addr  (instr_addr),
    .instr_gnt   (instr_gnt),
    .instr_rdata (instr_rdata),
    .instr_err   (instr_err),
    .instr_valid (instr_valid),
    .data_req    (data_req),
    .data_wr     (data_wr),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_byteen (data_byteen),
    .data_gnt    (data_gnt),
    .data_rdata  (data_rdata),
    .data_valid  (data_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        iq[$];
  exp_t        dq[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] imodel [0:3];
  logic [31:0] shadow [int];
  logic [31:0] dlast = 32'h0;
  int          igrants = 0;
  int          ivalids = 0;
  int          istalls = 0;

  // scoreboard: compare pending responses, then queue newly granted ones
  always @(negedge clk) begin
    exp_t        e;
    int          idx;
    logic [31:0] v;
    if (reset) begin
      iq.delete();
      dq.delete();
      dlast = 32'h0;
    end else begin
      if (instr_valid) begin
        ivalids++;
        checks++;
        if (iq.size() == 0) begin
          errors++;
          $display("FAIL instr_spurious got valid=1 want 0");
        end else begin
          e = iq.pop_front();
          if (instr_rdata !== e.data || instr_err !== e.err) begin
            errors++;
            $display("FAIL instr_resp got %h/%b want %h/%b",
                     instr_rdata, instr_err, e.data, e.err);
          end
        end
      end
      if (data_valid) begin
        checks++;
        if (dq.size() == 0) begin
          errors++;
          $display("FAIL data_spurious got valid=1 want 0");
        end else begin
          e = dq.pop_front();
          if (data_rdata !== e.data) begin
            errors++;
            $display("FAIL data_resp got %h want %h", data_rdata, e.data);
          end
        end
      end
      if (instr_req && instr_gnt) begin
        igrants++;
        idx = int'(instr_addr[31:2]);
        if (instr_addr[1:0] == 2'b00 && idx < IW) begin
          e.data = (idx < 4) ? imodel[idx] : 32'h0;
          e.err  = 1'b0;
        end else begin
          e.data = 32'h0;
          e.err  = 1'b1;
        end
        iq.push_back(e);
      end else if (instr_req) begin
        istalls++;
      end
      if (data_req && data_gnt) begin
        idx = int'(data_addr[31:2]);
        if (data_wr) begin
          if (idx < DW) begin
            v = shadow.exists(idx) ? shadow[idx] : 32'h0;
            for (int b = 0; b < 4; b++) begin
              if (data_byteen[b]) v[8*b +: 8] = data_wdata[8*b +: 8];
            end
            shadow[idx] = v;
          end
        end else begin
          dlast = (idx < DW && shadow.exists(idx)) ? shadow[idx] : 32'h0;
        end
        e.data = dlast;
        e.err  = 1'b0;
        dq.push_back(e);
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  task automatic fetch(input logic [31:0] a);
    int n = 0;
    instr_addr = a;
    instr_req  = 1'b1;
    @(negedge clk);
    while (!instr_gnt && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!instr_gnt) begin
      checks++;
      errors++;
      $display("FAIL fetch_gnt_timeout got 0 want 1");
    end
`ifndef TB_MEM_STALL_EN
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL fetch_gnt_wait got %0d want 0", n);
    end
`endif
    @(posedge clk);
    #2;
    instr_req = 1'b0;
  endtask

  task automatic data_op(input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
    int n = 0;
    data_wr     = wr;
    data_addr   = a;
    data_wdata  = wd;
    data_byteen = be;
    data_req    = 1'b1;
    @(negedge clk);
    while (!data_gnt && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!data_gnt) begin
      checks++;
      errors++;
      $display("FAIL data_gnt_timeout got 0 want 1");
    end
    @(posedge clk);
    #2;
    data_req = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((iq.size() != 0 || dq.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (iq.size() != 0 || dq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout got %0d/%0d pending want 0",
               iq.size(), dq.size());
    end
    sync();
  endtask

  task automatic test_reset();
    instr_req = 1'b1;
    data_req  = 1'b1;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || data_valid !== 1'b0 ||
        instr_err !== 1'b0 || instr_rdata !== 32'h0 ||
        data_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got %b%b%b %h %h want 000 0 0",
               instr_valid, data_valid, instr_err, instr_rdata, data_rdata);
    end
    checks++;
    if (instr_gnt !== 1'b0 || data_gnt !== 1'b0) begin
      errors++;
      $display("FAIL reset_gnt got %b%b want 00", instr_gnt, data_gnt);
    end
    instr_req = 1'b0;
    data_req  = 1'b0;
    repeat (2) sync();
    reset = 1'b0;
    sync();
  endtask

  task automatic test_fetch_seq();
    fetch(32'h0);
    fetch(32'h4);
    fetch(32'h8);
    fetch(32'hC);
    wait_idle();
  endtask

  task automatic test_fetch_err();
    fetch(32'h2);
    fetch(32'(IW * 4));
    wait_idle();
    checks++;
    if (instr_err !== 1'b0 || instr_rdata !== 32'h0) begin
      errors++;
      $display("FAIL fetch_idle_hold got %b %h want 0 0",
               instr_err, instr_rdata);
    end
  endtask

  task automatic test_store_merge();
    data_op(1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
    data_op(1'b1, 32'h100, 32'h0000AA00, 4'b0010);
    data_op(1'b0, 32'h100, 32'h0, 4'h0);
    wait_idle();
    checks++;
    if (data_rdata !== 32'hDEADAAEF) begin
      errors++;
      $display("FAIL store_merge got %h want deadaaef", data_rdata);
    end
    data_op(1'b1, 32'h100, 32'hFFFFFFFF, 4'h0);
    data_op(1'b0, 32'h103, 32'h0, 4'h0);
    data_op(1'b1, 32'(DW * 4), 32'hFFFFFFFF, 4'hF);
    data_op(1'b0, 32'(DW * 4), 32'h0, 4'h0);
    wait_idle();
    checks++;
    if (data_rdata !== 32'h0) begin
      errors++;
      $display("FAIL oor_load got %h want 0", data_rdata);
    end
  endtask

  task automatic test_dual();
    data_op(1'b1, 32'h200, 32'h12345678, 4'hF);
    wait_idle();
    fork
      fetch(32'h0);
      data_op(1'b0, 32'h200, 32'h0, 4'h0);
    join
`ifndef TB_MEM_STALL_EN
    #1;
    checks++;
    if (instr_valid !== 1'b1 || data_valid !== 1'b1) begin
      errors++;
      $display("FAIL dual_valid got %b%b want 11", instr_valid, data_valid);
    end
`endif
    wait_idle();
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    data_op(1'b0, 32'h100, 32'h0, 4'h0);
    reset = 1'b1;
    #1;
    checks++;
    if (data_valid !== 1'b0 || data_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid got %b %h want 0 0", data_valid, data_rdata);
    end
    repeat (2) sync();
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (data_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_discard got valid=1 want 0");
    end
    sync();
    data_op(1'b0, 32'h100, 32'h0, 4'h0);
    wait_idle();
    checks++;
    if (data_rdata !== 32'hDEADAAEF) begin
      errors++;
      $display("FAIL dram_preserved got %h want deadaaef", data_rdata);
    end
  endtask

  task automatic test_stall();
    int g0 = igrants;
    int v0 = ivalids;
    int s0 = istalls;
    instr_addr = 32'h4;
    instr_req  = 1'b1;
    repeat (64) @(negedge clk);
    @(posedge clk);
    #2;
    instr_req = 1'b0;
    wait_idle();
    checks++;
    if (igrants - g0 != ivalids - v0) begin
      errors++;
      $display("FAIL stall_balance got %0d want %0d",
               ivalids - v0, igrants - g0);
    end
    checks++;
`ifdef TB_MEM_STALL_EN
    if (istalls - s0 == 0) begin
      errors++;
      $display("FAIL stall_seen got 0 want >0");
    end
`else
    if (istalls - s0 != 0 || igrants - g0 != 64) begin
      errors++;
      $display("FAIL zero_wait got %0d/%0d want 0/64",
               istalls - s0, igrants - g0);
    end
`endif
  endtask

  initial begin
    imodel[0] = 32'h00000013;
    imodel[1] = 32'h00100093;
    imodel[2] = 32'h00200113;
    imodel[3] = 32'h00308193;
    for (int i = 0; i < 4; i++) dut.iram.MEM[i] = imodel[i];
    test_reset();
    test_fetch_seq();
    test_fetch_err();
    test_store_merge();
    test_dual();
    test_reset_mid();
    test_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
